// File: rtl/branch_ctrl.sv
// branch_ctrl: absolute branch/jump control for the program-counter stage.
// Decodes a 3-bit branch opcode, resolves targets through a writable target
// LUT, keeps a registered ALU condition flag and a call/return address stack.
module branch_ctrl #(
    parameter int T  = 12,
    parameter int LW = 5,
    parameter int D  = 4
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic [2:0]    Op,
    input  logic [LW-1:0] LutIdx,
    input  logic [T-1:0]  ProgCtr,
    input  logic          FlagIn,
    input  logic          FlagWe,
    input  logic          LutWe,
    input  logic [LW-1:0] LutWaddr,
    input  logic [T-1:0]  LutWdata,
    output logic          JumpAbs,
    output logic          BranchAbsEn,
    output logic          ALU_flag,
    output logic [T-1:0]  Target,
    output logic          StackOvf,
    output logic          StackUnf
);

    localparam int SPW = $clog2(D + 1);
    localparam int N   = 1 << LW;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_JMP  = 3'd1,
        OP_BRZ  = 3'd2,
        OP_BRNZ = 3'd3,
        OP_CALL = 3'd4,
        OP_RET  = 3'd5,
        OP_CLRF = 3'd6,
        OP_NOP7 = 3'd7
    } op_e;

    op_e op;
    assign op = op_e'(Op);

    logic           flag_q, flag_d;
    logic [T-1:0]   lut_q   [N];
    logic [T-1:0]   lut_d   [N];
    logic [T-1:0]   stack_q [D];
    logic [T-1:0]   stack_d [D];
    logic [SPW-1:0] sp_q, sp_d;
    logic           ovf_q, ovf_d;
    logic           unf_q, unf_d;

    logic           stack_full;
    logic           stack_empty;
    logic [T-1:0]   lut_tgt;
    logic [T-1:0]   ret_tgt;

    // Stack status, LUT read and top-of-stack read
    always_comb begin
        stack_full  = (sp_q == SPW'(D));
        stack_empty = (sp_q == '0);
        lut_tgt     = lut_q[LutIdx];
        ret_tgt     = '0;
        for (int unsigned i = 0; i < D; i++) begin
            if (SPW'(i) == sp_q - SPW'(1)) ret_tgt = stack_q[i];
        end
    end

    // Zero-cycle decode of the control presented to the PC stage;
    // reset gates the outputs so they drop without waiting for a clock
    always_comb begin
        JumpAbs     = 1'b0;
        BranchAbsEn = 1'b0;
        ALU_flag    = 1'b0;
        Target      = '0;
        if (Reset_n && !Start) begin
            unique case (op)
                OP_JMP: begin
                    JumpAbs = 1'b1;
                    Target  = lut_tgt;
                end
                OP_BRZ: begin
                    BranchAbsEn = 1'b1;
                    ALU_flag    = flag_q;
                    Target      = lut_tgt;
                end
                OP_BRNZ: begin
                    BranchAbsEn = 1'b1;
                    ALU_flag    = ~flag_q;
                    Target      = lut_tgt;
                end
                OP_CALL: begin
                    if (!stack_full) begin
                        JumpAbs = 1'b1;
                        Target  = lut_tgt;
                    end
                end
                OP_RET: begin
                    if (!stack_empty) begin
                        JumpAbs = 1'b1;
                        Target  = ret_tgt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign StackOvf = ovf_q;
    assign StackUnf = unf_q;

    // Next-state: LUT write, flag capture/clear, stack push/pop, error bits
    always_comb begin
        flag_d  = flag_q;
        lut_d   = lut_q;
        stack_d = stack_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;

        if (LutWe) lut_d[LutWaddr] = LutWdata;

        if (Start) begin
            flag_d = 1'b0;
            sp_d   = '0;
            ovf_d  = 1'b0;
            unf_d  = 1'b0;
        end else begin
            if (op == OP_CLRF)  flag_d = 1'b0;
            else if (FlagWe)    flag_d = FlagIn;

            if (op == OP_CALL) begin
                if (stack_full) begin
                    ovf_d = 1'b1;
                end else begin
                    for (int unsigned i = 0; i < D; i++) begin
                        if (SPW'(i) == sp_q) stack_d[i] = ProgCtr + T'(1);
                    end
                    sp_d = sp_q + SPW'(1);
                end
            end else if (op == OP_RET) begin
                if (stack_empty) unf_d = 1'b1;
                else             sp_d  = sp_q - SPW'(1);
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            flag_q  <= 1'b0;
            lut_q   <= '{default: '0};
            stack_q <= '{default: '0};
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            flag_q  <= flag_d;
            lut_q   <= lut_d;
            stack_q <= stack_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch/jump control unit that sits directly upstream of the program-counter stage and drives its JumpAbs, BranchAbsEn, ALU_flag and Target inputs. It decodes a 3-bit branch opcode from the instruction decoder and resolves absolute targets through a writable target lookup table (LUT). It holds a registered ALU condition flag and a return-address stack for call/return, so subroutine gosub and return to main run through absolute jumps.

## Interface
- T, 12, program-counter and target width
- LW, 5, LUT index width (2^LW entries of T bits)
- D, 4, return-stack depth (entries)

- Clk  in  1  clock, all state changes on posedge
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  synchronous program restart; clears flag, stack, error bits; LUT retained
- Op  in  3  branch opcode: 0 NOP, 1 JMP, 2 BRZ, 3 BRNZ, 4 CALL, 5 RET, 6 CLRF, 7 NOP
- LutIdx  in  LW  LUT index for JMP/BRZ/BRNZ/CALL
- ProgCtr  in  T  current program counter (address of the instruction carrying Op)
- FlagIn  in  1  ALU condition result
- FlagWe  in  1  capture FlagIn into the flag register
- LutWe  in  1  LUT write enable
- LutWaddr  in  LW  LUT write index
- LutWdata  in  T  LUT write data
- JumpAbs  out  1  unconditional absolute jump request
- BranchAbsEn  out  1  conditional absolute branch request
- ALU_flag  out  1  branch condition to the program-counter stage
- Target  out  T  absolute target address
- StackOvf  out  1  sticky: CALL attempted with stack full
- StackUnf  out  1  sticky: RET attempted with stack empty

## Operation
- State: flag register F, LUT[2^LW], stack[D], pointer SP (0..D, width clog2(D+1)), StackOvf, StackUnf.
- Reset_n low: F=0, SP=0, StackOvf=StackUnf=0, all LUT entries 0, stack entries 0. JumpAbs, BranchAbsEn, ALU_flag and Target are forced to 0 while reset is asserted.
- Outputs are combinational from Op and current state. Defaults: JumpAbs=0, BranchAbsEn=0, ALU_flag=0, Target=0.
- JMP: JumpAbs=1, Target=LUT[LutIdx].
- BRZ: BranchAbsEn=1, ALU_flag=F, Target=LUT[LutIdx].
- BRNZ: BranchAbsEn=1, ALU_flag=~F, Target=LUT[LutIdx].
- CALL, SP<D: JumpAbs=1, Target=LUT[LutIdx]. On the edge, stack[SP]<=ProgCtr+1 (mod 2^T) and SP<=SP+1.
- CALL, SP==D: no jump (outputs at defaults), no push, StackOvf<=1.
- RET, SP>0: JumpAbs=1, Target=stack[SP-1]. On the edge, SP<=SP-1.
- RET, SP==0: no jump, no pop, StackUnf<=1.
- CLRF: F<=0 on the edge. CLRF takes priority over a simultaneous FlagWe.
- FlagWe (Op≠CLRF): F<=FlagIn on the edge.
- LutWe: LUT[LutWaddr]<=LutWdata on the edge. A same-cycle read of that index returns the old value.
- Start high: all outputs at defaults regardless of Op. On the edge, F<=0, SP<=0, StackOvf<=0, StackUnf<=0. Op, FlagWe and stack effects are ignored. LutWe is still honoured.

## Timing
- Zero-cycle decode: the control seen by the program-counter stage on a given edge comes from the Op presented in that cycle.
- Branches test the registered F. A FlagWe in the same cycle as BRZ/BRNZ does not affect that branch; the new value is visible from the next cycle.
- A push or pop is visible to the next-cycle RET. CALL immediately followed by RET returns to ProgCtr_of_CALL+1.
- Error bits set on the edge after the faulting op. They are cleared only by reset or Start.
- Reset mid-operation: state clears asynchronously. Outputs go to 0 without waiting for Clk.

## Test plan
- Reset then LUT load: write LUT[3]=0x120. Op=JMP, LutIdx=3 -> JumpAbs=1, Target=0x120, BranchAbsEn=0.
- Flag timing: FlagIn=1 with FlagWe in cycle n, and BRZ in cycle n -> ALU_flag=0. BRZ in cycle n+1 -> ALU_flag=1. BRNZ in cycle n+1 -> ALU_flag=0.
- Nested call: CALL at PC 0x010 to LUT[1]=0x200, then CALL at 0x205 to LUT[2]=0x300, then RET, RET -> Target 0x206, then 0x011. SP ends at 0, no error bits set.
- Overflow/underflow: 5 CALLs with D=4 -> 5th gives JumpAbs=0 and StackOvf=1. 4 RETs succeed; the 5th gives JumpAbs=0 and StackUnf=1.
- Wrap: CALL at ProgCtr=0xFFF -> a later RET gives Target=0x000.
- Start/reset: Start asserted with Op=JMP -> JumpAbs=0. Afterwards SP=0, F=0, error bits cleared, LUT contents intact. Reset_n pulsed low between clock edges -> outputs go to 0 immediately.
